// File: rtl/alu_mult_seq.sv
// Sequential 4x4 unsigned shift-add multiplier that borrows the shared 4-bit ALU for its adds.
// The ALU has no carry-out, so the add carry is rebuilt from the operand and result MSBs.
module alu_mult_seq #(
  parameter int unsigned       N_BITS  = 4,
  parameter logic [3:0]        IDLE_OP = 4'b0000,
  parameter logic [3:0]        ADD_OP  = 4'b0010
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [N_BITS-1:0]     mcand,
  input  logic [N_BITS-1:0]     mplier,
  output logic                  busy,
  output logic                  done,
  output logic [2*N_BITS-1:0]   product,
  output logic                  zero,
  output logic [3:0]            alu_op,
  output logic [N_BITS-1:0]     alu_a,
  output logic [N_BITS-1:0]     alu_b,
  input  logic [N_BITS-1:0]     alu_r
);

  // state | meaning
  // IDLE  | ALU parked on a side-effect-free op, waiting for start
  // RUN   | one shift-add iteration per cycle, cnt = 0..3
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]        state;
  logic [N_BITS-1:0] hi, lo, m;
  logic [1:0]        cnt;

  logic [N_BITS-1:0] sum;
  logic              carry;
  logic [N_BITS-1:0] next_hi, next_lo;

  assign busy = (state == RUN);

  always_comb begin
    alu_op = IDLE_OP;
    alu_a  = '0;
    alu_b  = '0;
    if (state == RUN) begin
      alu_op = ADD_OP;
      alu_a  = hi;
      alu_b  = m;
    end
  end

  // Carry out of hi+m: both MSBs set, or one set and the result MSB dropped to 0.
  always_comb begin
    sum   = hi;
    carry = 1'b0;
    if (lo[0]) begin
      sum   = alu_r;
      carry = (hi[N_BITS-1] & m[N_BITS-1]) |
              ((hi[N_BITS-1] | m[N_BITS-1]) & ~alu_r[N_BITS-1]);
    end
  end

  assign next_hi = {carry, sum[N_BITS-1:1]};
  assign next_lo = {sum[0], lo[N_BITS-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      hi      <= '0;
      lo      <= '0;
      m       <= '0;
      cnt     <= '0;
      done    <= 1'b0;
      product <= '0;
      zero    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            m     <= mcand;
            lo    <= mplier;
            hi    <= '0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          hi  <= next_hi;
          lo  <= next_lo;
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            product <= {next_hi, next_lo};
            zero    <= ({next_hi, next_lo} == '0);
            done    <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
